// File: rtl/seg_mux_driver_pkg.sv
// seg_pkg: shared constants and helpers for the multiplexed 7-segment driver.
//   SEG_0..SEG_F : active-low glyph codes {dp, g,f,e,d,c,b,a} with dp off
//   SEG_BLANK    : every segment and the decimal point off
//   anode_onehot : one-hot anode select for a digit index (up to 8 digits)
//   idx_width    : bits needed to hold a counter value 0..n-1 (at least 1)
package seg_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_A     = 8'h88;
   localparam logic [7:0] SEG_B     = 8'h83;
   localparam logic [7:0] SEG_C     = 8'hC6;
   localparam logic [7:0] SEG_D     = 8'hA1;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_F     = 8'h8E;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [7:0] anode_onehot(input logic [2:0] idx);
      return 8'b0000_0001 << idx;
   endfunction

   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((2 ** w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/seg_mux_driver_if.sv
// seg_mux_driver_if: datapath-side and pin-side signals of the display driver.
//   value_in   : packed BCD/hex digits, digit 0 in bits [3:0]
//   dp_in      : per-digit decimal point request (1 = lit)
//   load       : capture value_in/dp_in into the shadow register
//   blank_en   : force all segments off
//   seg_out    : {dp, g,f,e,d,c,b,a}, active-low
//   an_out     : digit enables
//   frame_done : one-cycle pulse after the last digit slot of a frame
// master = producer of the display value, slave = the driver.
interface seg_mux_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    load;
   logic                    blank_en;
   logic [7:0]              seg_out;
   logic [NUM_DIGITS-1:0]   an_out;
   logic                    frame_done;

   modport master (
      output value_in, dp_in, load, blank_en,
      input  seg_out, an_out, frame_done
   );

   modport slave (
      input  value_in, dp_in, load, blank_en,
      output seg_out, an_out, frame_done
   );
endinterface

// File: rtl/seg_mux_driver_hex_decode.sv
// seg_hex_decode: combinational nibble to 7-segment encoder.
//   nibble   : digit code 0..15
//   dp       : 1 = decimal point lit
//   hex_mode : 1 = show A..F for 10..15, 0 = leave those segments dark
//   blank    : 1 = force the whole code to all-off
//   code     : {dp, g,f,e,d,c,b,a}, active-low
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       hex_mode,
   input  logic       blank,
   output logic [7:0] code
);

   logic [7:0] glyph;

   always_comb begin
      glyph = SEG_BLANK;
      case (nibble)
         4'h0: glyph = SEG_0;
         4'h1: glyph = SEG_1;
         4'h2: glyph = SEG_2;
         4'h3: glyph = SEG_3;
         4'h4: glyph = SEG_4;
         4'h5: glyph = SEG_5;
         4'h6: glyph = SEG_6;
         4'h7: glyph = SEG_7;
         4'h8: glyph = SEG_8;
         4'h9: glyph = SEG_9;
         4'hA: glyph = hex_mode ? SEG_A : SEG_BLANK;
         4'hB: glyph = hex_mode ? SEG_B : SEG_BLANK;
         4'hC: glyph = hex_mode ? SEG_C : SEG_BLANK;
         4'hD: glyph = hex_mode ? SEG_D : SEG_BLANK;
         4'hE: glyph = hex_mode ? SEG_E : SEG_BLANK;
         default: glyph = hex_mode ? SEG_F : SEG_BLANK;
      endcase

      // dp lives in bit 7 of the glyph table entries and is always off there
      if (blank) code = SEG_BLANK;
      else       code = {~dp, glyph[6:0]};
   end

endmodule

// File: rtl/seg_mux_driver.sv
// seg_mux_driver: time-multiplexed NUM_DIGITS-digit 7-segment display driver.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : seg_mux_driver_if slave (value_in, dp_in, load, blank_en in;
//           seg_out, an_out, frame_done out)
// Each digit owns REFRESH_DIV clocks; the first BLANK_CYCLES of a slot keep all
// anodes off to avoid ghosting. New values go to a shadow register and are only
// copied to the displayed (active) register at a frame boundary.
module seg_mux_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS       = 4,
   parameter int REFRESH_DIV      = 50000,
   parameter int BLANK_CYCLES     = 2,
   parameter int HEX_MODE         = 0,
   parameter int LZ_BLANK         = 1,
   parameter int ANODE_ACTIVE_LOW = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seg_mux_driver_if.slave        bus
);

   localparam int PS_W  = idx_width(REFRESH_DIV);
   localparam int DIG_W = idx_width(NUM_DIGITS);
   localparam logic [NUM_DIGITS-1:0] AN_OFF =
      (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic [PS_W-1:0]         ps_q;
   logic [DIG_W-1:0]        dig_q;
   logic [4*NUM_DIGITS-1:0] shadow_val;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic                    pending;
   logic [4*NUM_DIGITS-1:0] active_val;
   logic [NUM_DIGITS-1:0]   active_dp;

   logic                    slot_end;
   logic                    frame_bnd;
   logic                    guard;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_lz;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   an_sel;
   logic [NUM_DIGITS-1:0]   an_on;
   logic [7:0]              dec_code;

   logic [7:0]              seg_p1;
   logic [NUM_DIGITS-1:0]   an_p1;
   logic                    fd_p1;

   assign slot_end  = (ps_q == PS_W'(REFRESH_DIV - 1));
   assign frame_bnd = slot_end && (dig_q == DIG_W'(NUM_DIGITS - 1));
   assign guard     = (int'(ps_q) < BLANK_CYCLES);

   // Walk from the most significant digit down so zero_run holds "this digit
   // and everything above it is an undotted zero" when the selected digit is hit.
   always_comb begin
      cur_nib  = 4'd0;
      cur_dp   = 1'b0;
      cur_lz   = 1'b0;
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run && (active_val[4*k +: 4] == 4'd0) && !active_dp[k];
         if (dig_q == DIG_W'(k)) begin
            cur_nib = active_val[4*k +: 4];
            cur_dp  = active_dp[k];
            cur_lz  = (LZ_BLANK != 0) && (k != 0) && zero_run;
         end
      end
   end

   assign an_sel = NUM_DIGITS'(anode_onehot(3'(dig_q)));
   assign an_on  = (ANODE_ACTIVE_LOW != 0) ? ~an_sel : an_sel;

   // A leading-zero blanked digit keeps its anode on so every slot draws the
   // same duty cycle; only guard cycles turn the anodes off.
   seg_hex_decode u_decode (
      .nibble   (cur_nib),
      .dp       (cur_dp),
      .hex_mode (HEX_MODE != 0),
      .blank    (guard || bus.blank_en || cur_lz),
      .code     (dec_code)
   );

   // Scan counters and tear-free value registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ps_q       <= '0;
         dig_q      <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         pending    <= 1'b0;
         active_val <= '0;
         active_dp  <= '0;
      end else begin
         ps_q <= slot_end ? '0 : ps_q + PS_W'(1);
         if (slot_end) begin
            dig_q <= (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
         end

         // A load coinciding with the boundary bypasses the shadow entirely.
         if (bus.load && frame_bnd) begin
            active_val <= bus.value_in;
            active_dp  <= bus.dp_in;
            pending    <= 1'b0;
         end else if (bus.load) begin
            shadow_val <= bus.value_in;
            shadow_dp  <= bus.dp_in;
            pending    <= 1'b1;
         end else if (frame_bnd && pending) begin
            active_val <= shadow_val;
            active_dp  <= shadow_dp;
            pending    <= 1'b0;
         end
      end
   end

   // Output stage p1: registered pins, one clock after the scan state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_p1 <= SEG_BLANK;
         an_p1  <= AN_OFF;
         fd_p1  <= 1'b0;
      end else begin
         seg_p1 <= dec_code;
         an_p1  <= guard ? AN_OFF : an_on;
         fd_p1  <= frame_bnd;
      end
   end

   assign bus.seg_out    = seg_p1;
   assign bus.an_out     = an_p1;
   assign bus.frame_done = fd_p1;

endmodule

// File: tb/tb_seg_mux_driver.sv
// tb_seg_mux_driver: bench for seg_mux_driver with NUM_DIGITS=4, REFRESH_DIV=4,
// BLANK_CYCLES=1, active-low anodes. Two instances share stimulus: dut0 with
// HEX_MODE=0 and dut1 with HEX_MODE=1.
module tb_seg_mux_driver;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   seg_mux_driver_if #(.NUM_DIGITS(4)) bus0 ();
   seg_mux_driver_if #(.NUM_DIGITS(4)) bus1 ();

   assign bus1.value_in = bus0.value_in;
   assign bus1.dp_in    = bus0.dp_in;
   assign bus1.load     = bus0.load;
   assign bus1.blank_en = bus0.blank_en;

   seg_mux_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
      .HEX_MODE(0), .LZ_BLANK(1), .ANODE_ACTIVE_LOW(1)
   ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

   seg_mux_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
      .HEX_MODE(1), .LZ_BLANK(1), .ANODE_ACTIVE_LOW(1)
   ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef struct packed {
      logic [7:0] seg0;
      logic [7:0] seg1;
      logic [3:0] an;
      logic       fd;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   fails  = 0;

   // reference state of the display
   int         m_ps, m_dig;
   logic [15:0] m_act, m_sh;
   logic [3:0]  m_actdp, m_shdp;
   bit          m_pend;

   logic [7:0] glyph_tab [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   function automatic logic [7:0] ref_code(input logic [3:0] nib, input logic dpb, input bit hex);
      logic [7:0] c;
      c = glyph_tab[nib];
      if (nib > 4'd9 && !hex) c = 8'hFF;
      c[7] = ~dpb;
      return c;
   endfunction

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: predict the outputs of this edge, advance, compare.
   task automatic step();
      exp_t        e, got;
      bit          guard, lz;
      logic [3:0]  nib;
      logic        ld;
      logic [15:0] val;
      logic [3:0]  dpv;
      ld  = bus0.load;
      val = bus0.value_in;
      dpv = bus0.dp_in;
      if (!rst_n) begin
         e = '{seg0: 8'hFF, seg1: 8'hFF, an: 4'hF, fd: 1'b0};
      end else begin
         guard = (m_ps < 1);
         e.fd  = (m_ps == 3 && m_dig == 3);
         e.an  = guard ? 4'hF : ~(4'b0001 << m_dig);
         lz = 1'b0;
         if (m_dig != 0) begin
            lz = 1'b1;
            for (int j = m_dig; j < 4; j++)
               if (m_act[4*j +: 4] != 4'd0 || m_actdp[j]) lz = 1'b0;
         end
         nib = m_act[4*m_dig +: 4];
         if (guard || bus0.blank_en || lz) begin
            e.seg0 = 8'hFF;
            e.seg1 = 8'hFF;
         end else begin
            e.seg0 = ref_code(nib, m_actdp[m_dig], 1'b0);
            e.seg1 = ref_code(nib, m_actdp[m_dig], 1'b1);
         end
      end
      sb.push_back(e);

      @(posedge clk);
      #1;

      if (!rst_n) begin
         m_ps = 0; m_dig = 0; m_act = '0; m_sh = '0;
         m_actdp = '0; m_shdp = '0; m_pend = 1'b0;
      end else begin
         if (ld && e.fd) begin
            m_act = val; m_actdp = dpv; m_pend = 1'b0;
         end else if (ld) begin
            m_sh = val; m_shdp = dpv; m_pend = 1'b1;
         end else if (e.fd && m_pend) begin
            m_act = m_sh; m_actdp = m_shdp; m_pend = 1'b0;
         end
         if (m_ps == 3) begin
            m_ps  = 0;
            m_dig = (m_dig + 1) % 4;
         end else begin
            m_ps++;
         end
      end

      got = sb.pop_front();
      check8("seg_hex0", bus0.seg_out, got.seg0);
      check8("seg_hex1", bus1.seg_out, got.seg1);
      check8("an_out", 8'(bus0.an_out), 8'(got.an));
      check8("frame_done", 8'(bus0.frame_done), 8'(got.fd));
   endtask

   task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
      bus0.value_in = v;
      bus0.dp_in    = dp;
      bus0.load     = 1'b1;
      step();
      bus0.load     = 1'b0;
   endtask

   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (bus0.frame_done !== 1'b1 && n < 40);
      check8({tag, "_frame_seen"}, 8'(bus0.frame_done), 8'h01);
   endtask

   // Run until dut0 selects the given anode, then check both segment buses.
   task automatic expect_digit(input string tag, input logic [3:0] an,
                               input logic [7:0] s0, input logic [7:0] s1);
      int n;
      n = 0;
      while (bus0.an_out !== an && n < 20) begin
         step();
         n++;
      end
      check8({tag, "_an"}, 8'(bus0.an_out), 8'(an));
      check8({tag, "_seg_hex0"}, bus0.seg_out, s0);
      check8({tag, "_seg_hex1"}, bus1.seg_out, s1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_fd, n_guard, n;
      rst_n         = 1'b0;
      bus0.value_in = '0;
      bus0.dp_in    = '0;
      bus0.load     = 1'b0;
      bus0.blank_en = 1'b0;
      m_ps = 0; m_dig = 0; m_act = '0; m_sh = '0;
      m_actdp = '0; m_shdp = '0; m_pend = 1'b0;

      // reset held for three edges, then the first guard cycle
      repeat (3) step();
      rst_n = 1'b1;
      step();
      check8("rst_seg", bus0.seg_out, 8'hFF);
      check8("rst_an", 8'(bus0.an_out), 8'h0F);
      check8("rst_fd", 8'(bus0.frame_done), 8'h00);

      // scan 1234: digit0 holds 4, digit3 holds 1
      load_val(16'h1234, 4'b0000);
      wait_frame("scan");
      expect_digit("scan_d0", 4'hE, 8'h99, 8'h99);
      expect_digit("scan_d1", 4'hD, 8'hB0, 8'hB0);
      expect_digit("scan_d2", 4'hB, 8'hA4, 8'hA4);
      expect_digit("scan_d3", 4'h7, 8'hF9, 8'hF9);

      // guard cycles and frame pulses across two frames
      n_fd = 0;
      n_guard = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (bus0.frame_done === 1'b1) n_fd++;
         if (bus0.an_out === 4'hF) n_guard++;
      end
      check8("frame_pulses", 8'(n_fd), 8'd2);
      check8("guard_cycles", 8'(n_guard), 8'd8);

      // leading zeros
      load_val(16'h0050, 4'b0000);
      wait_frame("lz");
      expect_digit("lz_d0", 4'hE, 8'hC0, 8'hC0);
      expect_digit("lz_d1", 4'hD, 8'h92, 8'h92);
      expect_digit("lz_d2", 4'hB, 8'hFF, 8'hFF);
      expect_digit("lz_d3", 4'h7, 8'hFF, 8'hFF);

      // a dotted zero stops leading-zero blanking below it
      load_val(16'h0000, 4'b0100);
      wait_frame("lzdp");
      expect_digit("lzdp_d1", 4'hD, 8'hC0, 8'hC0);
      expect_digit("lzdp_d2", 4'hB, 8'h40, 8'h40);
      expect_digit("lzdp_d3", 4'h7, 8'hFF, 8'hFF);

      // hex digits: dut0 dark, dut1 shows A and F
      load_val(16'h00AF, 4'b0000);
      wait_frame("hex");
      expect_digit("hex_d0", 4'hE, 8'hFF, 8'h8E);
      expect_digit("hex_d1", 4'hD, 8'hFF, 8'h88);

      // tear-free: two loads inside one frame, last one wins at the boundary
      wait_frame("tear_start");
      repeat (5) step();
      load_val(16'h1111, 4'b0000);
      repeat (3) step();
      load_val(16'h2222, 4'b0000);
      expect_digit("tear_old_d3", 4'h7, 8'hFF, 8'hFF);
      wait_frame("tear");
      expect_digit("tear_d0", 4'hE, 8'hA4, 8'hA4);
      expect_digit("tear_d1", 4'hD, 8'hA4, 8'hA4);
      expect_digit("tear_d2", 4'hB, 8'hA4, 8'hA4);
      expect_digit("tear_d3", 4'h7, 8'hA4, 8'hA4);

      // load on the exact boundary cycle goes straight to the display
      n = 0;
      while (!(m_ps == 3 && m_dig == 3) && n < 20) begin
         step();
         n++;
      end
      load_val(16'h9999, 4'b0000);
      check8("sim_fd", 8'(bus0.frame_done), 8'h01);
      expect_digit("sim_d0", 4'hE, 8'h90, 8'h90);
      expect_digit("sim_d3", 4'h7, 8'h90, 8'h90);
      wait_frame("sim_next");
      expect_digit("sim_next_d1", 4'hD, 8'h90, 8'h90);

      // global blank for five cycles while scanning continues
      bus0.blank_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check8("blank_seg", bus0.seg_out, 8'hFF);
      end
      bus0.blank_en = 1'b0;
      repeat (4) step();

      // reset with a pending load discards the shadow
      wait_frame("rst_mid_start");
      repeat (3) step();
      load_val(16'h4321, 4'b0000);
      repeat (2) step();
      rst_n = 1'b0;
      step();
      check8("rst_mid_seg", bus0.seg_out, 8'hFF);
      check8("rst_mid_an", 8'(bus0.an_out), 8'h0F);
      rst_n = 1'b1;
      expect_digit("rst_mid_d0", 4'hE, 8'hC0, 8'hC0);
      wait_frame("rst_mid");
      expect_digit("rst_mid_next_d0", 4'hE, 8'hC0, 8'hC0);
      expect_digit("rst_mid_next_d1", 4'hD, 8'hFF, 8'hFF);
      repeat (4) step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
